// File: rtl/down_counter_8bit.sv
// Presettable down counter with one-shot or auto-reload terminal behaviour.
// Emits a registered one-cycle borrow pulse when the count runs from 1 to its terminal value.
module down_counter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Rd,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  input  logic             Auto,
  output logic [WIDTH-1:0] Q,
  output logic             Bout,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             bout_q, bout_d;

  always_ff @(posedge CLK or negedge Rd) begin
    if (!Rd) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    bout_d   = 1'b0;

    if (Load) begin
      count_d  = D;
      reload_d = D;
      state_d  = (D != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          // A zero count while running is treated as a corrupted state and parked in IDLE.
          if (count_q == '0) begin
            state_d = IDLE;
          end else if (En) begin
            if (count_q == WIDTH'(1)) begin
              bout_d = 1'b1;
              if (Auto) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign Q    = count_q;
  assign Bout = bout_q;
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_8bit.sv
// Scoreboard bench for down_counter_8bit: stimulus queues hand-computed expectations,
// a monitor pops and compares one entry after every rising edge while entries are pending.
`timescale 1ns/1ps
module tb_down_counter_8bit;

  logic       CLK;
  logic       Rd;
  logic       Load;
  logic [7:0] D;
  logic       En;
  logic       Auto;
  logic [7:0] Q;
  logic       Bout;
  logic       Busy;
  logic       Done;

  typedef struct {
    logic [7:0] q;
    logic       bout;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  down_counter_8bit #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .Rd   (Rd),
    .Load (Load),
    .D    (D),
    .En   (En),
    .Auto (Auto),
    .Q    (Q),
    .Bout (Bout),
    .Busy (Busy),
    .Done (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the state expected after the next rising edge.
  task automatic applyStimulus(input logic ld, input logic [7:0] dv, input logic en, input logic au,
                               input logic [7:0] eq, input logic eb, input logic ebusy,
                               input logic edone, input string tag);
    exp_t e;
    @(negedge CLK);
    Load = ld;
    D    = dv;
    En   = en;
    Auto = au;
    e.q    = eq;
    e.bout = eb;
    e.busy = ebusy;
    e.done = edone;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge CLK);
    #2;
    checkOutput("drain", sb.size(), 0);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".Q"},    int'(Q),    int'(e.q));
      checkOutput({e.tag, ".Bout"}, int'(Bout), int'(e.bout));
      checkOutput({e.tag, ".Busy"}, int'(Busy), int'(e.busy));
      checkOutput({e.tag, ".Done"}, int'(Done), int'(e.done));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rd   = 1'b0;
    Load = 1'b0;
    D    = 8'd0;
    En   = 1'b0;
    Auto = 1'b0;

    // Reset held while inputs toggle randomly.
    repeat (4) begin
      @(negedge CLK);
      Load = 1'($urandom_range(0, 1));
      En   = 1'($urandom_range(0, 1));
      D    = 8'($urandom_range(1, 255));
    end
    @(posedge CLK);
    #2;
    checkOutput("rst_hold.Q",    int'(Q),    0);
    checkOutput("rst_hold.Bout", int'(Bout), 0);
    checkOutput("rst_hold.Busy", int'(Busy), 0);
    checkOutput("rst_hold.Done", int'(Done), 0);
    @(negedge CLK);
    Load = 1'b0;
    En   = 1'b0;
    Rd   = 1'b1;
    @(posedge CLK);
    #2;
    checkOutput("rst_rel.Q",    int'(Q),    0);
    checkOutput("rst_rel.Busy", int'(Busy), 0);
    checkOutput("rst_rel.Done", int'(Done), 0);

    // One-shot from 3.
    applyStimulus(1, 8'd3, 1, 0, 8'd3, 0, 1, 0, "os_load");
    applyStimulus(0, 8'd0, 1, 0, 8'd2, 0, 1, 0, "os_2");
    applyStimulus(0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "os_1");
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 1, 0, 1, "os_term");
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 0, 0, 1, "os_after1");
    applyStimulus(0, 8'd0, 1, 1, 8'd0, 0, 0, 1, "os_after2");
    waitDrain();

    // Auto-reload from 4: twelve enabled edges after the load.
    applyStimulus(1, 8'd4, 1, 1, 8'd4, 0, 1, 0, "ar_load");
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 8'd0, 1, 1, 8'(4 - ((k - 1) % 4 + 1) % 4 == 4 ? 4 : 4 - k % 4),
                    (k % 4 == 0), 1, 0, $sformatf("ar_%0d", k));
    end
    waitDrain();

    // Enable gating; Auto toggled on disabled edges must not matter.
    applyStimulus(1, 8'd2, 0, 0, 8'd2, 0, 1, 0, "eg_load");
    applyStimulus(0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "eg_en1");
    applyStimulus(0, 8'd0, 0, 1, 8'd1, 0, 1, 0, "eg_en0a");
    applyStimulus(0, 8'd0, 0, 1, 8'd1, 0, 1, 0, "eg_en0b");
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 1, 0, 1, "eg_term");
    waitDrain();

    // Load priority over a terminal edge, then load of zero.
    applyStimulus(1, 8'd2, 1, 0, 8'd2, 0, 1, 0, "lp_load");
    applyStimulus(0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "lp_1");
    applyStimulus(1, 8'd7, 1, 0, 8'd7, 0, 1, 0, "lp_load7");
    applyStimulus(1, 8'd0, 1, 1, 8'd0, 0, 0, 0, "lp_load0");
    applyStimulus(0, 8'd0, 1, 1, 8'd0, 0, 0, 0, "lp_idle");
    waitDrain();

    // Reload value 1: borrow on every enabled edge.
    applyStimulus(1, 8'd1, 1, 1, 8'd1, 0, 1, 0, "r1_load");
    applyStimulus(0, 8'd0, 1, 1, 8'd1, 1, 1, 0, "r1_a");
    applyStimulus(0, 8'd0, 1, 1, 8'd1, 1, 1, 0, "r1_b");
    applyStimulus(0, 8'd0, 1, 1, 8'd1, 1, 1, 0, "r1_c");
    applyStimulus(0, 8'd0, 0, 1, 8'd1, 0, 1, 0, "r1_hold");
    waitDrain();

    // Full-scale one-shot: 255 enabled edges to the borrow.
    applyStimulus(1, 8'hFF, 1, 0, 8'd255, 0, 1, 0, "ff_load");
    for (int k = 1; k <= 254; k++) begin
      applyStimulus(0, 8'd0, 1, 0, 8'(255 - k), 0, 1, 0, $sformatf("ff_%0d", k));
    end
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 1, 0, 1, "ff_term");
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 0, 0, 1, "ff_nowrap");
    waitDrain();

    // Asynchronous reset while running at Q=5.
    applyStimulus(1, 8'd8, 1, 0, 8'd8, 0, 1, 0, "mr_load");
    applyStimulus(0, 8'd0, 1, 0, 8'd7, 0, 1, 0, "mr_7");
    applyStimulus(0, 8'd0, 1, 0, 8'd6, 0, 1, 0, "mr_6");
    applyStimulus(0, 8'd0, 1, 0, 8'd5, 0, 1, 0, "mr_5");
    applyStimulus(0, 8'd0, 0, 0, 8'd5, 0, 1, 0, "mr_hold");
    waitDrain();
    @(posedge CLK);
    #3;
    Rd = 1'b0;
    #1;
    checkOutput("mr_async.Q",    int'(Q),    0);
    checkOutput("mr_async.Bout", int'(Bout), 0);
    checkOutput("mr_async.Busy", int'(Busy), 0);
    checkOutput("mr_async.Done", int'(Done), 0);
    @(negedge CLK);
    En = 1'b1;
    @(posedge CLK);
    #2;
    checkOutput("mr_held.Q",    int'(Q),    0);
    checkOutput("mr_held.Bout", int'(Bout), 0);
    @(negedge CLK);
    Rd = 1'b1;
    En = 1'b0;
    applyStimulus(0, 8'd0, 1, 0, 8'd0, 0, 0, 0, "mr_after");
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
